// File: rtl/prime_pkg.sv
// Shared types and constants for the prime tester.
// Holds the FSM state enum and divider timing constants.
package prime_pkg;

  localparam int FIRST_ODD_DIVISOR = 3;
  localparam int DIV_LATENCY       = 17;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_SQR,
    S_DIV,
    S_WAIT,
    S_RESULT
  } state_t;

endpackage

// File: rtl/prime_test_ctrl_if.sv
// Request/result bundle of the prime tester.
// master: start, n out; slave: busy, done, is_prime, factor out.
interface prime_test_ctrl_if #(
  parameter int WIDTH = 16
);

  logic             start;
  logic [WIDTH-1:0] n;
  logic             busy;
  logic             done;
  logic             is_prime;
  logic [WIDTH-1:0] factor;

  modport master (
    output start,
    output n,
    input  busy,
    input  done,
    input  is_prime,
    input  factor
  );

  modport slave (
    input  start,
    input  n,
    output busy,
    output done,
    output is_prime,
    output factor
  );

endinterface

// File: rtl/seq_divider.sv
// Restoring divider, one quotient bit per cycle; yields remainder.
// Ports: clk, reset, div_start, dividend, divisor -> remainder, div_done.
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             div_start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH:0]   divisor,
  output logic [WIDTH:0]   remainder,
  output logic             div_done
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [CW-1:0]    cnt;
  logic             run;

  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] diff;
  logic             ge;
  logic [WIDTH:0]   rem_nx;

  // Partial remainder stays below divisor, so the
  // restored value always fits back into WIDTH+1 bits.
  assign shifted = {rem_q, quo_q[WIDTH-1]};
  assign ge      = shifted >= {1'b0, divisor};
  assign diff    = shifted - {1'b0, divisor};
  assign rem_nx  = ge ? diff[WIDTH:0]
                      : shifted[WIDTH:0];

  assign remainder = rem_q;

  // Load cycle plus WIDTH shift cycles: done
  // rises WIDTH+1 cycles after div_start.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q    <= '0;
      quo_q    <= '0;
      cnt      <= '0;
      run      <= 1'b0;
      div_done <= 1'b0;
    end else begin
      div_done <= 1'b0;
      if (div_start) begin
        rem_q <= '0;
        quo_q <= dividend;
        cnt   <= CW'(WIDTH);
        run   <= 1'b1;
      end else if (run) begin
        rem_q <= rem_nx;
        quo_q <= {quo_q[WIDTH-2:0], ge};
        cnt   <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          run      <= 1'b0;
          div_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/prime_test_ctrl.sv
// Trial-division primality tester with smallest-factor result.
// Ports: CLOCK_50, reset, bus (start, n -> busy, done, is_prime, factor).
module prime_test_ctrl
  import prime_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic            CLOCK_50,
  input  logic            reset,
  prime_test_ctrl_if.slave bus
);

  state_t           state;
  logic [WIDTH-1:0] n_q;
  logic [WIDTH:0]   d;
  logic             res_prime;
  logic [WIDTH-1:0] res_factor;
  logic             busy_q;
  logic             done_q;
  logic             prime_q;
  logic [WIDTH-1:0] factor_q;

  logic [2*WIDTH+1:0] sq;
  logic               over;
  logic               div_start;
  logic [WIDTH:0]     rem;
  logic               div_done;

  // Full-width square: d reaches 257 for WIDTH=16.
  assign sq = {{(WIDTH+1){1'b0}}, d}
            * {{(WIDTH+1){1'b0}}, d};
  assign over = sq > {{(WIDTH+2){1'b0}}, n_q};

  assign div_start = (state == S_DIV);

  seq_divider #(
    .WIDTH(WIDTH)
  ) u_div (
    .clk      (CLOCK_50),
    .reset    (reset),
    .div_start(div_start),
    .dividend (n_q),
    .divisor  (d),
    .remainder(rem),
    .div_done (div_done)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= S_IDLE;
      n_q        <= '0;
      d          <= '0;
      res_prime  <= 1'b0;
      res_factor <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      prime_q    <= 1'b0;
      factor_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (bus.start) begin
            n_q    <= bus.n;
            d      <= (WIDTH+1)'(FIRST_ODD_DIVISOR);
            busy_q <= 1'b1;
            state  <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (n_q < WIDTH'(2)) begin
            res_prime  <= 1'b0;
            res_factor <= '0;
            state      <= S_RESULT;
          end else if (n_q < WIDTH'(4)) begin
            res_prime  <= 1'b1;
            res_factor <= n_q;
            state      <= S_RESULT;
          end else if (!n_q[0]) begin
            res_prime  <= 1'b0;
            res_factor <= WIDTH'(2);
            state      <= S_RESULT;
          end else begin
            state <= S_SQR;
          end
        end
        S_SQR: begin
          if (over) begin
            res_prime  <= 1'b1;
            res_factor <= n_q;
            state      <= S_RESULT;
          end else begin
            state <= S_DIV;
          end
        end
        S_DIV: begin
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (div_done) begin
            if (rem == '0) begin
              res_prime  <= 1'b0;
              res_factor <= d[WIDTH-1:0];
              state      <= S_RESULT;
            end else begin
              d     <= d + (WIDTH+1)'(2);
              state <= S_SQR;
            end
          end
        end
        S_RESULT: begin
          prime_q  <= res_prime;
          factor_q <= res_factor;
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.is_prime = prime_q;
  assign bus.factor   = factor_q;

endmodule
